// File: rtl/multisim_push_buffer_pkg.sv
// Shared definitions for the multisim push buffer: default depth, the depth
// legality check, and the statistics record used when statistics are built in.
package multisim_push_pkg;

  localparam int MULTISIM_PUSH_DEFAULT_DEPTH = 8;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  typedef struct packed {
    logic [63:0] beats;
    logic [63:0] stall_cycles;
    logic [31:0] max_count;
  } multisim_push_stats_t;

endpackage

// File: rtl/multisim_push_buffer_mem.sv
// Storage array for the push buffer: one synchronous write port and one
// asynchronous read port. Pointer and occupancy control lives in the parent.
module multisim_fifo_mem
  import multisim_push_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = MULTISIM_PUSH_DEFAULT_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; occupancy tracking decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/multisim_push_buffer.sv
// Elastic FIFO in front of the multisim push client. Defining
// MULTISIM_PUSH_BUFFER_STATS_EN adds beat/stall/high-water statistics outputs.
module multisim_push_buffer
  import multisim_push_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = MULTISIM_PUSH_DEFAULT_DEPTH,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count
`ifdef MULTISIM_PUSH_BUFFER_STATS_EN
  ,
  output logic [63:0]           stat_beats,
  output logic [63:0]           stat_stall_cycles,
  output logic [CW-1:0]         stat_max_count
`endif
);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("multisim_push_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready depends only on registered occupancy, keeping out_rdy off the in_rdy path.
  assign in_rdy  = (count != CW'(DEPTH));
  assign out_vld = (count != '0);
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  multisim_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

`ifdef MULTISIM_PUSH_BUFFER_STATS_EN
  logic [63:0]          beats_q;
  logic [63:0]          stall_q;
  logic [CW-1:0]        max_q;
  multisim_push_stats_t stats;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q <= '0;
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      if (push && beats_q != '1) beats_q <= beats_q + 64'd1;
      if (out_vld && !out_rdy && stall_q != '1) stall_q <= stall_q + 64'd1;
      if (count > max_q) max_q <= count;
    end
  end

  assign stat_beats        = beats_q;
  assign stat_stall_cycles = stall_q;
  assign stat_max_count    = max_q;
  assign stats             = '{beats: beats_q, stall_cycles: stall_q, max_count: 32'(max_q)};

  final begin
    $display("%m: beats=%0d stall_cycles=%0d max_count=%0d",
             stats.beats, stats.stall_cycles, stats.max_count);
  end
`endif

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count == '0));
  a_in_data_known: assert property (@(posedge clk) disable iff (!rst_n)
    in_vld |-> !$isunknown(in_data));
`endif

endmodule

// File: tb/tb_multisim_push_buffer.sv
// Scoreboard bench for multisim_push_buffer: a queue model tracks accepted
// beats and a negedge monitor compares every presented output against it.
module tb_multisim_push_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
`ifdef MULTISIM_PUSH_BUFFER_STATS_EN
  logic [63:0]   stat_beats;
  logic [63:0]   stat_stall_cycles;
  logic [CW-1:0] stat_max_count;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model_q[$];
  bit            model_live = 1'b0;
  longint        accepted = 0;
  longint        exp_stalls = 0;
  int            exp_max = 0;
  bit            do_push;
  bit            do_pop;

  always #5 clk = ~clk;

  multisim_push_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_data           (in_data),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_data          (out_data),
    .count             (count)
`ifdef MULTISIM_PUSH_BUFFER_STATS_EN
    ,
    .stat_beats        (stat_beats),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_max_count    (stat_max_count)
`endif
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic vld, input logic [DW-1:0] data, input logic rdy);
    @(posedge clk);
    #1;
    rst_n   = rst;
    in_vld  = vld;
    in_data = data;
    out_rdy = rdy;
  endtask

  // Reference model: a FIFO of accepted beats, updated with the handshake rules at each edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      exp_stalls = 0;
      exp_max    = 0;
      model_live = 1'b1;
    end else begin
      do_pop  = out_rdy && (model_q.size() > 0);
      do_push = in_vld && (model_q.size() < DEPTH);
      if (model_q.size() > 0 && !out_rdy) exp_stalls++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(in_data);
        accepted++;
      end
      if (model_q.size() > exp_max) exp_max = model_q.size();
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check_output("count", 64'(count), 64'(model_q.size()));
      check_output("in_rdy", 64'(in_rdy), 64'(model_q.size() != DEPTH));
      check_output("out_vld", 64'(out_vld), 64'(model_q.size() != 0));
      if (model_q.size() > 0) check_output("out_data", out_data, model_q[0]);
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint start;
    int     cycles;

    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("reset_count", 64'(count), 64'd0);
    check_output("reset_out_vld", 64'(out_vld), 64'd0);
    check_output("reset_in_rdy", 64'(in_rdy), 64'd1);

    $display("[TB] fill to full with out_rdy low");
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 1'b1, DW'(i), 1'b0);
    apply_stimulus(1'b1, 1'b1, DW'(9), 1'b0);
    @(negedge clk);
    check_output("full_count", 64'(count), 64'd8);
    check_output("full_in_rdy", 64'(in_rdy), 64'd0);
    check_output("full_head", out_data, 64'h1);
    apply_stimulus(1'b1, 1'b1, DW'(9), 1'b0);
    apply_stimulus(1'b1, 1'b1, DW'(9), 1'b0);
    @(negedge clk);
    check_output("held_count", 64'(count), 64'd8);
    check_output("held_head", out_data, 64'h1);

    $display("[TB] drain from full");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("drain_count", 64'(count), 64'd0);
    check_output("drain_out_vld", 64'(out_vld), 64'd0);

    $display("[TB] streaming push and pop");
    for (int i = 0; i < 100; i++) apply_stimulus(1'b1, 1'b1, DW'(32'h100 + i), 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] random traffic");
    start  = accepted;
    cycles = 0;
    while ((accepted - start) < 10000 && cycles < 60000) begin
      apply_stimulus(1'b1, $urandom_range(0, 99) < 70, {$urandom, $urandom}, $urandom_range(0, 99) < 30);
      cycles++;
    end
    check_output("random_beats_done", 64'((accepted - start) >= 10000), 64'd1);
    cycles = 0;
    while (model_q.size() > 0 && cycles < 50) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b1);
      cycles++;
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("random_drained", 64'(count), 64'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, DW'(32'h50 + i), 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("midreset_count", 64'(count), 64'd0);
    check_output("midreset_out_vld", 64'(out_vld), 64'd0);
    check_output("midreset_in_rdy", 64'(in_rdy), 64'd1);
    apply_stimulus(1'b1, 1'b1, DW'(8'hAA), 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("post_reset_head", out_data, 64'hAA);
    check_output("post_reset_count", 64'(count), 64'd1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("post_reset_empty", 64'(count), 64'd0);

`ifdef MULTISIM_PUSH_BUFFER_STATS_EN
    $display("[TB] statistics");
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    start = accepted;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("stat_beats", stat_beats, 64'(accepted - start));
    check_output("stat_beats_const", stat_beats, 64'd8);
    check_output("stat_stall_cycles", stat_stall_cycles, 64'(exp_stalls));
    check_output("stat_max_count", 64'(stat_max_count), 64'(exp_max));
    check_output("stat_max_const", 64'(stat_max_count), 64'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
